// File: rtl/apb_slave_pkg.sv
// Shared definitions for the APB register-file completer: FSM state encoding,
// wait-counter width, register-index width helper and the privileged index.
package apb_slave_pkg;

  // Transfer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wide enough for the largest wait-state count (15)
  localparam int WAIT_CNT_W = 4;

  // Register 0 is the privileged register when APB4 support is compiled in
  localparam int PRIV_REG_IDX = 0;

  // Index width for a bank of n registers (never narrower than one bit)
  function automatic int reg_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register bank: NUM_REGS words of DATA_WIDTH bits, one byte-enabled
// synchronous write port and one combinational read port.
module apb_reg_bank
  import apb_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = reg_idx_width(NUM_REGS)
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      // One word: cleared on reset, bytes updated where the strobe is set
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          regs[gi] <= '0;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) begin
              regs[gi][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
          end
        end
      end
    end
  endgenerate

  assign rd_data = regs[rd_idx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a register bank and WAIT_CYCLES wait states.
// Optional feature macro: APB4_EN adds PSTRB (byte-lane writes) and PPROT
// (register 0 requires PPROT[0]=1, otherwise the access errors).
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB4_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int  IDX_W     = reg_idx_width(NUM_REGS);
  localparam int  STRB_W    = DATA_WIDTH / 8;
  localparam bit  ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t                  state_reg;
  logic [WAIT_CNT_W-1:0]   cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic                    write_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [STRB_W-1:0]       strb_reg;
  logic                    err_reg;
  logic [DATA_WIDTH-1:0]   prdata_reg;
  logic                    pready_reg;
  logic                    pslverr_reg;

  logic [IDX_W-1:0]        setup_idx;
  logic [STRB_W-1:0]       setup_strb;
  logic                    setup_err;
  logic                    setup_hit;
  logic [IDX_W-1:0]        rd_idx;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    wr_en;

  assign setup_idx = PADDR[2 +: IDX_W];
  assign setup_hit = PSELx && !PENABLE;

  // Decode the setup-phase address: misaligned, beyond the bank, or privileged
  always_comb begin
    setup_err  = (PADDR[1:0] != 2'b00) || (|PADDR[ADDR_WIDTH-1:2+IDX_W]);
`ifdef APB4_EN
    setup_strb = PSTRB;
    if ((setup_idx == IDX_W'(PRIV_REG_IDX)) && !PPROT[0]) begin
      setup_err = 1'b1;
    end
`else
    setup_strb = '1;
`endif
  end

  // Zero-wait transfers look up the live address; otherwise the captured one
  assign rd_idx = (state_reg == IDLE) ? setup_idx : idx_reg;

  // Writes commit on the edge that ends the response cycle
  assign wr_en = (state_reg == RESP) && write_reg && !err_reg;

  apb_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .wr_en   (wr_en),
    .wr_idx  (idx_reg),
    .wr_data (wdata_reg),
    .wr_strb (strb_reg),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Transfer FSM with registered PREADY/PSLVERR/PRDATA
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      write_reg   <= 1'b0;
      wdata_reg   <= '0;
      strb_reg    <= '0;
      err_reg     <= 1'b0;
      prdata_reg  <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          pready_reg  <= 1'b0;
          pslverr_reg <= 1'b0;
          prdata_reg  <= '0;
          if (setup_hit) begin
            idx_reg   <= setup_idx;
            write_reg <= PWRITE;
            wdata_reg <= PWDATA;
            strb_reg  <= setup_strb;
            err_reg   <= setup_err;
            cnt_reg   <= WAIT_CNT_W'(WAIT_CYCLES);
            if (ZERO_WAIT) begin
              state_reg   <= RESP;
              pready_reg  <= 1'b1;
              pslverr_reg <= setup_err;
              prdata_reg  <= (setup_err || PWRITE) ? '0 : rd_data;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!PSELx) begin
            // Master abandoned the transfer: drop it without touching the bank
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg <= WAIT_CNT_W'(1)) begin
              state_reg   <= RESP;
              pready_reg  <= 1'b1;
              pslverr_reg <= err_reg;
              prdata_reg  <= (err_reg || write_reg) ? '0 : rd_data;
            end
          end
        end
        RESP: begin
          state_reg   <= IDLE;
          pready_reg  <= 1'b0;
          pslverr_reg <= 1'b0;
          prdata_reg  <= '0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign PRDATA  = prdata_reg;
  assign PREADY  = pready_reg;
  assign PSLVERR = pslverr_reg;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: two instances (2 and 0 wait
// states) on a shared bus, directed scenarios plus randomized traffic checked
// against an array model of the register bank.
module tb_apb_slave_regfile;

  localparam int NREGS = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        psel_w2, psel_w0;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata_w2, prdata_w0;
  logic        pready_w2, pready_w0;
  logic        pslverr_w2, pslverr_w0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mdl[d][i] is register i of instance d (0 -> 0 waits, 1 -> 2 waits)
  logic [31:0] mdl [2][NREGS];

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(.WAIT_CYCLES(2)) u_dut_w2 (
    .PCLK (PCLK), .PRESETn (PRESETn), .PSELx (psel_w2), .PENABLE (penable),
    .PADDR (paddr), .PWRITE (pwrite), .PWDATA (pwdata),
`ifdef APB4_EN
    .PSTRB (pstrb), .PPROT (pprot),
`endif
    .PRDATA (prdata_w2), .PREADY (pready_w2), .PSLVERR (pslverr_w2)
  );

  apb_slave_regfile #(.WAIT_CYCLES(0)) u_dut_w0 (
    .PCLK (PCLK), .PRESETn (PRESETn), .PSELx (psel_w0), .PENABLE (penable),
    .PADDR (paddr), .PWRITE (pwrite), .PWDATA (pwdata),
`ifdef APB4_EN
    .PSTRB (pstrb), .PPROT (pprot),
`endif
    .PRDATA (prdata_w0), .PREADY (pready_w0), .PSLVERR (pslverr_w0)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NREGS; i++) mdl[d][i] = '0;
  endtask

  function automatic logic exp_err(input logic [31:0] addr, input logic [2:0] prot);
    logic e;
    e = (addr % 4 != 0) || ((addr / 4) >= NREGS);
`ifdef APB4_EN
    if ((addr / 4) == 0 && !prot[0]) e = 1'b1;
`endif
    return e;
  endfunction

  // Drive one complete transfer on instance d; called #1 after a clock edge,
  // returns #1 after the edge following the response with the bus idle.
  task automatic apb_xfer(input int d, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot, output logic [31:0] rdata,
                          output logic err, output int lat);
    paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; pprot = prot;
    penable = 1'b0;
    if (d == 1) psel_w2 = 1'b1; else psel_w0 = 1'b1;
    @(posedge PCLK); #1;
    penable = 1'b1;
    lat = 1;
    while (!((d == 1) ? pready_w2 : pready_w0) && lat < 40) begin
      @(posedge PCLK); #1;
      lat++;
    end
    rdata = (d == 1) ? prdata_w2 : prdata_w0;
    err   = (d == 1) ? pslverr_w2 : pslverr_w0;
    @(posedge PCLK); #1;
    psel_w2 = 1'b0; psel_w0 = 1'b0; penable = 1'b0;
  endtask

  // Transfer plus comparison against the model; model updated on good writes
  task automatic do_xfer(input string tag, input int d, input logic [31:0] addr,
                         input logic wr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot,
                         output logic [31:0] rdata);
    logic        e_err, g_err;
    int          lat, idx;
    logic [31:0] e_rd;
    e_err = exp_err(addr, prot);
    idx   = int'(addr / 4) % NREGS;
    e_rd  = (e_err || wr) ? 32'h0 : mdl[d][idx];
    apb_xfer(d, addr, wr, wdata, strb, prot, rdata, g_err, lat);
    check_val({tag, "_lat"}, 32'(lat), (d == 1) ? 32'd3 : 32'd1);
    check_val({tag, "_err"}, {31'h0, g_err}, {31'h0, e_err});
    if (!wr) check_val({tag, "_rd"}, rdata, e_rd);
    if (wr && !e_err) begin
      for (int b = 0; b < 4; b++) begin
`ifdef APB4_EN
        if (strb[b]) mdl[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
`else
        mdl[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
`endif
      end
    end
    $display("xfer %s dut=%0d %s addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0d lat=%0d",
             tag, d, wr ? "WR" : "RD", addr, wdata, rdata, g_err, lat);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] addr;
    int          seen;
    int          d;

    PRESETn = 1'b0;
    psel_w2 = 1'b0; psel_w0 = 1'b0; penable = 1'b0;
    paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = 4'hF; pprot = 3'b001;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    check_val("rst_pready", {31'h0, pready_w2}, 32'h0);
    check_val("rst_prdata", prdata_w2, 32'h0);
    check_val("rst_pslverr", {31'h0, pslverr_w0}, 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Write then read back with two wait states
    do_xfer("wr04", 1, 32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, rd);
    do_xfer("rd04", 1, 32'h04, 1'b0, 32'h0, 4'hF, 3'b001, rd);
    check_val("rd04_lit", rd, 32'hDEADBEEF);

    // Out-of-range read and misaligned write
    do_xfer("rd40", 1, 32'h40, 1'b0, 32'h0, 4'hF, 3'b001, rd);
    do_xfer("wr41", 1, 32'h41, 1'b1, 32'h1234, 4'hF, 3'b001, rd);
    do_xfer("rd00", 1, 32'h00, 1'b0, 32'h0, 4'hF, 3'b001, rd);

    // Zero-wait back-to-back writes, then read both
    do_xfer("b2b_wr00", 0, 32'h00, 1'b1, 32'h11223344, 4'hF, 3'b001, rd);
    do_xfer("b2b_wr3c", 0, 32'h3C, 1'b1, 32'hCAFEF00D, 4'hF, 3'b001, rd);
    do_xfer("b2b_rd00", 0, 32'h00, 1'b0, 32'h0, 4'hF, 3'b001, rd);
    do_xfer("b2b_rd3c", 0, 32'h3C, 1'b0, 32'h0, 4'hF, 3'b001, rd);
    check_val("b2b_rd3c_lit", rd, 32'hCAFEF00D);

    // PSELx dropped during WAIT: no response, register unchanged
    do_xfer("ab_wr10", 1, 32'h10, 1'b1, 32'hA5A5A5A5, 4'hF, 3'b001, rd);
    paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h5A5A5A5A; penable = 1'b0; psel_w2 = 1'b1;
    @(posedge PCLK); #1;
    penable = 1'b1;
    seen = 0;
    @(posedge PCLK); #1;
    psel_w2 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (pready_w2) seen++;
      @(posedge PCLK); #1;
    end
    check_val("abort_pready", 32'(seen), 32'h0);
    do_xfer("ab_rd10", 1, 32'h10, 1'b0, 32'h0, 4'hF, 3'b001, rd);
    check_val("ab_rd10_lit", rd, 32'hA5A5A5A5);

`ifdef APB4_EN
    // Byte strobes and privileged register 0
    do_xfer("s_wr08", 1, 32'h08, 1'b1, 32'h0, 4'hF, 3'b001, rd);
    do_xfer("s_wrst", 1, 32'h08, 1'b1, 32'hAABBCCDD, 4'b0101, 3'b001, rd);
    do_xfer("s_rd08", 1, 32'h08, 1'b0, 32'h0, 4'hF, 3'b001, rd);
    check_val("s_rd08_lit", rd, 32'h00BB00DD);
    do_xfer("p_wr00", 1, 32'h00, 1'b1, 32'h77777777, 4'hF, 3'b000, rd);
    do_xfer("p_rd00", 1, 32'h00, 1'b0, 32'h0, 4'hF, 3'b001, rd);
`endif

    // Randomized traffic on both instances
    for (int n = 0; n < 80; n++) begin
      int r;
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 7)       addr = 32'($urandom_range(0, NREGS - 1)) * 4;
      else if (r == 7) addr = 32'($urandom_range(0, NREGS - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 8) addr = 32'h40 + 32'($urandom_range(0, 63)) * 4;
      else             addr = $urandom;
`ifdef APB4_EN
      pstrb = 4'($urandom);
      pprot = 3'($urandom);
`endif
      do_xfer("rnd", d, addr, 1'($urandom), $urandom, pstrb, pprot, rd);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge PCLK); #1;
      end
    end
    pstrb = 4'hF; pprot = 3'b001;

    // Reset asserted mid-WAIT loses the pending write and clears the bank
    do_xfer("r_wr08", 1, 32'h08, 1'b1, 32'h55AA55AA, 4'hF, 3'b001, rd);
    paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h12345678; penable = 1'b0; psel_w2 = 1'b1;
    @(posedge PCLK); #1;
    penable = 1'b1;
    PRESETn = 1'b0;
    #1;
    check_val("rmid_pready", {31'h0, pready_w2}, 32'h0);
    check_val("rmid_prdata", prdata_w2, 32'h0);
    model_reset();
    psel_w2 = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    do_xfer("r_rd08", 1, 32'h08, 1'b0, 32'h0, 4'hF, 3'b001, rd);
    check_val("r_rd08_lit", rd, 32'h0);
    do_xfer("r_rd3c", 0, 32'h3C, 1'b0, 32'h0, 4'hF, 3'b001, rd);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer (slave) holding a bank of word-wide registers, sitting directly downstream of the APB master. Consumes PSELx/PENABLE/PADDR/PWRITE/PWDATA (plus PSTRB/PPROT when APB4 support is compiled in) and returns PRDATA/PREADY/PSLVERR. Inserts a parameterised number of wait states, and flags errors for bad addresses. Serves as the team's reference completer for closed-loop master/slave simulation.

## Interface
- ADDR_WIDTH, 32, width of PADDR
- DATA_WIDTH, 32, width of PWDATA/PRDATA; multiple of 8
- NUM_REGS, 16, number of registers; power of two, ≥2
- WAIT_CYCLES, 2, access-phase cycles with PREADY low before the completing cycle; 0..15
- PCLK  in  1  clock, rising edge
- PRESETn  in  1  asynchronous active-low reset
- PSELx  in  1  completer select
- PENABLE  in  1  access-phase indicator
- PADDR  in  ADDR_WIDTH  byte address
- PWRITE  in  1  1 = write, 0 = read
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  byte strobes (APB4_EN only)
- PPROT  in  3  protection attributes (APB4_EN only)
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer completion
- PSLVERR  out  1  transfer error, valid only with PREADY

## Operation
- Reset: PREADY=0, PSLVERR=0, PRDATA=0, all registers 0, FSM=IDLE, wait counter 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on PSELx=1 & PENABLE=0 (setup), capture addr/write/data (and strb/prot), load counter with WAIT_CYCLES, compute error. Go to RESP if WAIT_CYCLES=0, else WAIT.
- WAIT: decrement counter each cycle; at counter=1 go to RESP. If PSELx=0, abort to IDLE, no register change.
- RESP: PREADY=1 for exactly one cycle. PSLVERR is the captured error. Then IDLE.
- A write commits at the edge ending RESP, only if error=0.
- Read: PRDATA = reg[index] during RESP. PRDATA is 0 during RESP when error=1, and 0 in all other states.
- Decode: index = PADDR[2 +: log2(NUM_REGS)].
- Error sources:
  - PADDR[1:0]≠0.
  - PADDR[ADDR_WIDTH-1:2] ≥ NUM_REGS.
- Back-to-back transfers: a setup cycle immediately after RESP is accepted normally, because the FSM is already in IDLE.
- Reset asserted mid-transfer: immediate return to IDLE with reset values. The pending write is lost.

## Timing
- Setup at cycle T0 → PREADY=1 at T0+1+WAIT_CYCLES.
- WAIT_CYCLES=0 → PREADY in the first access cycle (T0+1).
- PRDATA, PREADY and PSLVERR are registered outputs; no combinational input-to-output path.
- Register content is visible to a read whose setup cycle follows the write's RESP cycle.

## Configuration
- APB4_EN defined: PSTRB and PPROT ports exist.
  - Writes update only bytes with PSTRB[i]=1; PSTRB=0 is a legal no-op write.
  - Register 0 is privileged: any access with PPROT[0]=0 → PSLVERR=1, no write, PRDATA=0.
- APB4_EN undefined: no PSTRB/PPROT ports, full-word writes, no privilege check.

## Structure
- Shared package apb_slave_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - WAIT counter width constant
  - register index width function/constant
  - privileged-register index constant (0)
- Sub-module apb_reg_bank: register array with byte-enable write port and combinational read port, same PCLK/PRESETn.

## Test plan
- Reset mid-WAIT (PRESETn low at T0+1): → PREADY=0, PRDATA=0 immediately; a later read of 0x08 returns 0.
- Write 0xDEADBEEF to 0x04, then read 0x04, WAIT_CYCLES=2: → PREADY high at T0+3 both times, PSLVERR=0, read returns 0xDEADBEEF.
- Read 0x40 (index 16, NUM_REGS=16): → PREADY at T0+3, PSLVERR=1, PRDATA=0. Write 0x1234 to 0x41: → PSLVERR=1, no register changes.
- WAIT_CYCLES=0, back-to-back writes to 0x00 and 0x3C with no idle gap: → PREADY at T0+1 and T0+3; both values read back.
- PSELx dropped at T0+2 during WAIT: → no PREADY, register unchanged; the next transfer completes normally.
- APB4_EN, write 0xAABBCCDD with PSTRB=4'b0101 to 0x08 (pre-loaded 0): → reads 0x00BB00DD. Write to 0x00 with PPROT=3'b000: → PSLVERR=1, value unchanged.
